alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Sequences one request at a time through a fixed-latency ALU.
// Operands are held stable while the ALU works. Illegal requests are answered with an error and never reach the ALU.
module alu_sequencer #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [3:0]  req_tag,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_cmd,
    input  logic [14:0] alu_res,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [14:0] rsp_data,
    output logic [3:0]  rsp_tag,
    output logic        rsp_err,
    output logic        busy
);

    // LATENCY must be at least 1; the counter holds values from 0 to LATENCY.
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_CAPTURE, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        alu_a_q, alu_a_d;
    logic [15:0]        alu_b_q, alu_b_d;
    logic [2:0]         alu_cmd_q, alu_cmd_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [14:0]        rsp_data_q, rsp_data_d;
    logic [3:0]         rsp_tag_q, rsp_tag_d;
    logic               rsp_err_q, rsp_err_d;
    logic               req_bad;

    // Op 7 is undefined. DV0 and DV1 with a zero divisor magnitude would hang or corrupt the ALU.
    assign req_bad = (req_op == 3'd7) ||
                     (((req_op == 3'd5) || (req_op == 3'd6)) && (req_b[15:1] == 15'd0));

    always_comb begin
        // NOTE: every next-state signal takes its current value first, so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cmd_d   = alu_cmd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rsp_tag_d = req_tag;
                    if (req_bad) begin
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        alu_a_d   = req_a;
                        alu_b_d   = req_b;
                        alu_cmd_d = req_op;
                        cnt_d     = CNT_W'(LATENCY);
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rsp_data_d  = alu_res;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cmd_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cmd_q   <= alu_cmd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cmd   = alu_cmd_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer.
// A two-stage pipelined ALU model supplies alu_res; every expected result below is hand-computed.
module tb_alu_sequencer;

    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_tag;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_cmd;
    logic [14:0] alu_res;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [14:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_sequencer #(.LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU model: the operand magnitude is bits 15:1, and the result appears two edges after the operands.
    function automatic logic [14:0] alu_f(input logic [2:0] cmd, input logic [15:0] a, input logic [15:0] b);
        logic [14:0] av;
        logic [14:0] bv;
        logic [29:0] prod;
        av   = a[15:1];
        bv   = b[15:1];
        prod = av * bv;
        case (cmd)
            3'd0:    return av + bv;
            3'd1:    return av - bv;
            3'd2:    return av & bv;
            3'd3:    return prod[14:0];
            3'd4:    return prod[29:15];
            3'd5:    return (bv != 0) ? av / bv : 15'd0;
            3'd6:    return (bv != 0) ? av % bv : 15'd0;
            default: return 15'd0;
        endcase
    endfunction

    logic [14:0] pipe1, pipe2;
    always @(posedge clk) begin
        pipe1 <= alu_f(alu_cmd, alu_a, alu_b);
        pipe2 <= pipe1;
    end
    assign alu_res = pipe2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, " rsp_data"},  32'(rsp_data),  32'd0);
        check({tag, " rsp_tag"},   32'(rsp_tag),   32'd0);
        check({tag, " alu_a"},     32'(alu_a),     32'd0);
        check({tag, " alu_b"},     32'(alu_b),     32'd0);
        check({tag, " alu_cmd"},   32'(alu_cmd),   32'd0);
    endtask

    // Presents one request and returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
        check("ready before accept", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Counts edges until rsp_valid is seen. An expired budget is reported as a failure.
    task automatic wait_rsp(output int edges);
        edges = 0;
        while (!rsp_valid && edges < 50) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        if (!rsp_valid) check("rsp timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("release rsp_valid", 32'(rsp_valid), 32'd0);
        check("release req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int n;
        bit got1;
        time t0, t1;

        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // ADD 3+4: the result is visible after the third edge following the accept edge.
        issue(3'd0, 16'h0006, 16'h0008, 4'd3);
        check("add busy",    32'(busy),      32'd1);
        check("add ready",   32'(req_ready), 32'd0);
        check("add alu_a",   32'(alu_a),     32'h0006);
        check("add alu_b",   32'(alu_b),     32'h0008);
        check("add alu_cmd", 32'(alu_cmd),   32'd0);
        wait_rsp(edges);
        check("add latency", 32'(edges),    32'(LATENCY + 1));
        check("add data",    32'(rsp_data), 32'd7);
        check("add tag",     32'(rsp_tag),  32'd3);
        check("add err",     32'(rsp_err),  32'd0);
        release_rsp();

        // DV1 with a zero divisor magnitude (bit 0 alone is ignored) is rejected at once.
        issue(3'd6, 16'h0010, 16'h0001, 4'd11);
        check("dv0 valid",   32'(rsp_valid), 32'd1);
        check("dv0 err",     32'(rsp_err),   32'd1);
        check("dv0 data",    32'(rsp_data),  32'd0);
        check("dv0 tag",     32'(rsp_tag),   32'd11);
        check("dv0 alu_cmd", 32'(alu_cmd),   32'd0);
        check("dv0 alu_a",   32'(alu_a),     32'h0006);
        check("dv0 alu_b",   32'(alu_b),     32'h0008);
        release_rsp();

        issue(3'd7, 16'h0010, 16'h0020, 4'd12);
        check("op7 valid",   32'(rsp_valid), 32'd1);
        check("op7 err",     32'(rsp_err),   32'd1);
        check("op7 data",    32'(rsp_data),  32'd0);
        check("op7 tag",     32'(rsp_tag),   32'd12);
        check("op7 alu_cmd", 32'(alu_cmd),   32'd0);
        release_rsp();

        // When IDLE, rsp_ready without a pending response has no effect.
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle rsp_ready busy",  32'(busy),      32'd0);
        check("idle rsp_ready valid", 32'(rsp_valid), 32'd0);

        // SUB 20-3=17, then ten cycles of backpressure while the request inputs are changed.
        issue(3'd1, 16'h0028, 16'h0006, 4'd9);
        wait_rsp(edges);
        check("sub latency", 32'(edges), 32'(LATENCY + 1));
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_op    = 3'(i);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            req_tag   = 4'(i);
            check("bp valid", 32'(rsp_valid), 32'd1);
            check("bp data",  32'(rsp_data),  32'd17);
            check("bp tag",   32'(rsp_tag),   32'd9);
            check("bp err",   32'(rsp_err),   32'd0);
            check("bp ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        release_rsp();

        // AND 0xFF & 0x787 = 0x87, with the request inputs toggled while the ALU works.
        issue(3'd2, 16'h01FE, 16'h0F0E, 4'd4);
        for (int i = 0; i <= LATENCY; i++) begin
            req_valid = 1'b1;
            req_op    = 3'($urandom);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            check("stab alu_a",   32'(alu_a),   32'h01FE);
            check("stab alu_b",   32'(alu_b),   32'h0F0E);
            check("stab alu_cmd", 32'(alu_cmd), 32'd2);
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("stab valid", 32'(rsp_valid), 32'd1);
        check("stab data",  32'(rsp_data),  32'h87);
        check("stab tag",   32'(rsp_tag),   32'd4);
        release_rsp();

        // A reset in the second HOLD cycle, away from any clock edge, discards the operation.
        issue(3'd0, 16'h0006, 16'h0008, 4'd10);
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("post reset valid", 32'(rsp_valid), 32'd0);
            check("post reset busy",  32'(busy),      32'd0);
        end

        // Back-to-back: MP0 3x5=15, then AND 7&6=6, with the consumer always ready.
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = 3'd3; req_a = 16'h0006; req_b = 16'h000A; req_tag = 4'd5;
        @(posedge clk);
        t0 = $time;
        @(negedge clk);
        req_op = 3'd2; req_a = 16'h000E; req_b = 16'h000C; req_tag = 4'd6;
        n = 0;
        got1 = 1'b0;
        while (!req_ready && n < 20) begin
            if (rsp_valid && !got1) begin
                check("b2b mp0 data", 32'(rsp_data), 32'd15);
                check("b2b mp0 tag",  32'(rsp_tag),  32'd5);
                check("b2b mp0 err",  32'(rsp_err),  32'd0);
                got1 = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("b2b first rsp seen", 32'(got1), 32'd1);
        @(posedge clk);
        t1 = $time;
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b spacing", 32'((t1 - t0) / 10), 32'(LATENCY + 3));
        wait_rsp(edges);
        check("b2b and data", 32'(rsp_data), 32'd6);
        check("b2b and tag",  32'(rsp_tag),  32'd6);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("b2b final idle", 32'(req_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
